// File: rtl/img_cam_core.sv
// rtl/img_cam_core.sv - parametrised CAM core: write/clear/read plus two-stage associative search.
// Define CAM_MASK_EN to add the key_mask port (1 = ignore that key bit during compare).
module img_cam_core #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              match_en,
  input  logic [DATA_W-1:0] key,
`ifdef CAM_MASK_EN
  input  logic [DATA_W-1:0] key_mask,
`endif
  output logic              match_valid,
  output logic              hit,
  output logic              multi_hit,
  output logic [ADDR_W-1:0] match_addr,
  output logic [ADDR_W:0]   match_count,
  output logic [ADDR_W:0]   used
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W:0]   used_q, used_d;

  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;

  logic              s1_valid_q;
  logic [DEPTH-1:0]  s1_vec_q, match_d;

  logic              match_valid_q, hit_q, multi_hit_q;
  logic [ADDR_W-1:0] match_addr_q, enc_addr;
  logic [ADDR_W:0]   match_count_q, enc_cnt;

  logic              addr_ok, wr_ok, clr_ok;
  logic [DATA_W-1:0] rd_word, cmp_mask;

  // Out-of-range addresses never touch state; clear takes priority over write.
  assign addr_ok = {1'b0, addr} < DEPTH_L;
  assign clr_ok  = !rst && clr_en && addr_ok;
  assign wr_ok   = !rst && we && !clr_en && addr_ok;
  assign rd_word = addr_ok ? mem_q[addr] : '0;

`ifdef CAM_MASK_EN
  assign cmp_mask = ~key_mask;
`else
  assign cmp_mask = '1;
`endif

  always_comb begin
    valid_d = valid_q;
    used_d  = used_q;
    if (clr_ok) begin
      valid_d[addr] = 1'b0;
      if (valid_q[addr]) used_d = used_q - 1'b1;
    end else if (wr_ok) begin
      valid_d[addr] = 1'b1;
      if (!valid_q[addr]) used_d = used_q + 1'b1;
    end
  end

  // Compares use pre-edge contents, so a same-cycle write is not seen.
  always_comb begin
    match_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_d[i] = valid_q[i] && (((mem_q[i] ^ key) & cmp_mask) == '0);
    end
  end

  always_comb begin
    enc_addr = '0;
    enc_cnt  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (s1_vec_q[i]) begin
        enc_addr = ADDR_W'(i);
        enc_cnt  = enc_cnt + 1'b1;
      end
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[addr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      used_q        <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_vec_q      <= '0;
      match_valid_q <= 1'b0;
      hit_q         <= 1'b0;
      multi_hit_q   <= 1'b0;
      match_addr_q  <= '0;
      match_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      used_q       <= used_d;
      dout_valid_q <= rd_en;
      if (rd_en) dout_q <= rd_word;

      s1_valid_q <= match_en;
      if (match_en) s1_vec_q <= match_d;

      match_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        hit_q         <= enc_cnt != '0;
        multi_hit_q   <= enc_cnt > (ADDR_W+1)'(1);
        match_addr_q  <= enc_addr;
        match_count_q <= enc_cnt;
      end
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign match_valid = match_valid_q;
  assign hit         = hit_q;
  assign multi_hit   = multi_hit_q;
  assign match_addr  = match_addr_q;
  assign match_count = match_count_q;
  assign used        = used_q;

endmodule

// File: tb/tb_img_cam_core.sv
// tb/tb_img_cam_core.sv - randomized self-checking bench for img_cam_core against a behavioural model.
// Define CAM_MASK_EN to also exercise key_mask.
module tb_img_cam_core;
  localparam int DATA_W = 14;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst, we, clr_en, rd_en, match_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din, key;
`ifdef CAM_MASK_EN
  logic [DATA_W-1:0] key_mask;
`endif
  logic [DATA_W-1:0] dout;
  logic              dout_valid, match_valid, hit, multi_hit;
  logic [ADDR_W-1:0] match_addr;
  logic [ADDR_W:0]   match_count, used;

  int checks = 0;
  int errors = 0;

  img_cam_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .we(we), .clr_en(clr_en), .addr(addr), .din(din),
    .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid),
    .match_en(match_en), .key(key),
`ifdef CAM_MASK_EN
    .key_mask(key_mask),
`endif
    .match_valid(match_valid), .hit(hit), .multi_hit(multi_hit),
    .match_addr(match_addr), .match_count(match_count), .used(used)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  // Behavioural model: contents, valid flags, and expected visible outputs.
  logic [DATA_W-1:0] mem_m [DEPTH];
  bit                valid_m [DEPTH];
  bit                p1_v;
  int                p1_cnt, p1_low;
  bit                e_mv, e_hit, e_multi, e_dv;
  int                e_addr, e_cnt;
  logic [DATA_W-1:0] e_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] care_bits();
`ifdef CAM_MASK_EN
    return ~key_mask;
`else
    return '1;
`endif
  endfunction

  function automatic int n_valid();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += valid_m[i] ? 1 : 0;
    return n;
  endfunction

  task automatic idle();
    rst = 1'b0; we = 1'b0; clr_en = 1'b0; rd_en = 1'b0; match_en = 1'b0;
    addr = '0; din = '0; key = '0;
`ifdef CAM_MASK_EN
    key_mask = '0;
`endif
  endtask

  task automatic tick();
    int found;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) valid_m[i] = 1'b0;
      p1_v = 1'b0; e_mv = 1'b0; e_hit = 1'b0; e_multi = 1'b0;
      e_addr = 0; e_cnt = 0; e_dv = 1'b0; e_dout = '0;
    end else begin
      e_mv = p1_v;
      if (p1_v) begin
        e_hit = p1_cnt > 0; e_multi = p1_cnt > 1; e_addr = p1_low; e_cnt = p1_cnt;
      end
      p1_v = match_en;
      if (match_en) begin
        found = 0; p1_low = 0;
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_m[i] && (((mem_m[i] ^ key) & care_bits()) == '0)) begin
            if (found == 0) p1_low = i;
            found++;
          end
        end
        p1_cnt = found;
      end
      e_dv = rd_en;
      if (rd_en) e_dout = mem_m[addr];
      if (clr_en) valid_m[addr] = 1'b0;
      else if (we) begin
        mem_m[addr] = din; valid_m[addr] = 1'b1;
      end
    end
    @(negedge clk);
    check("match_valid", match_valid, e_mv);
    check("hit", hit, e_hit);
    check("multi_hit", multi_hit, e_multi);
    check("match_addr", match_addr, e_addr);
    check("match_count", match_count, e_cnt);
    check("dout_valid", dout_valid, e_dv);
    check("dout", dout, e_dout);
    check("used", used, n_valid());
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    idle(); we = 1'b1; addr = ADDR_W'(a); din = d; tick(); idle();
  endtask

  task automatic clr(input int a);
    idle(); clr_en = 1'b1; addr = ADDR_W'(a); tick(); idle();
  endtask

  task automatic search(input logic [DATA_W-1:0] k);
    idle(); match_en = 1'b1; key = k; tick(); idle(); tick();
  endtask

  logic [DATA_W-1:0] pool [4];

  initial begin
    idle();
    rst = 1'b1; tick(); tick();
    check("rst_used", used, 0);
    check("rst_match_valid", match_valid, 0);
    check("rst_dout", dout, 0);
    idle();

    for (int i = 0; i < DEPTH; i++) wr(i, '0);
    for (int i = 0; i < DEPTH; i++) clr(i);

    wr(0, 14'h0001); wr(5, 14'h0002);
    search(14'h0002);
    check("p1_mv", match_valid, 1); check("p1_hit", hit, 1);
    check("p1_addr", match_addr, 5); check("p1_cnt", match_count, 1);
    check("p1_used", used, 2);

    wr(3, 14'h0ABC); wr(7, 14'h0ABC); wr(12, 14'h0ABC);
    search(14'h0ABC);
    check("p2_addr", match_addr, 3); check("p2_multi", multi_hit, 1);
    check("p2_cnt", match_count, 3); check("p2_used", used, 5);
    clr(3);
    search(14'h0ABC);
    check("p2c_addr", match_addr, 7); check("p2c_cnt", match_count, 2);
    check("p2c_used", used, 4);

    match_en = 1'b1; key = 14'h0001; tick();
    key = 14'h3FFF; tick();
    check("b2b0_mv", match_valid, 1); check("b2b0_hit", hit, 1); check("b2b0_addr", match_addr, 0);
    key = 14'h0002; tick();
    check("b2b1_mv", match_valid, 1); check("b2b1_hit", hit, 0); check("b2b1_addr", match_addr, 0);
    idle(); tick();
    check("b2b2_mv", match_valid, 1); check("b2b2_hit", hit, 1); check("b2b2_addr", match_addr, 5);
    tick();
    check("b2b_end_mv", match_valid, 0);

    we = 1'b1; addr = 4'd9; din = 14'h1111; match_en = 1'b1; key = 14'h1111; tick();
    idle(); match_en = 1'b1; key = 14'h1111; tick();
    check("rw_same_mv", match_valid, 1); check("rw_same_hit", hit, 0);
    idle(); tick();
    check("rw_next_hit", hit, 1); check("rw_next_addr", match_addr, 9);
    rd_en = 1'b1; addr = 4'd5; tick(); idle();
    check("rd5", dout, 14'h0002);
    we = 1'b1; clr_en = 1'b1; addr = 4'd9; din = 14'h1111; tick(); idle();
    search(14'h1111);
    check("weclr_hit", hit, 0); check("weclr_used", used, 4);

    match_en = 1'b1; key = 14'h0002; tick();
    idle(); rst = 1'b1; tick();
    check("rst_mid_mv", match_valid, 0); check("rst_mid_used", used, 0);
    idle(); tick();
    check("rst_after_mv", match_valid, 0);
    search(14'h0002);
    check("rst_srch_mv", match_valid, 1); check("rst_srch_hit", hit, 0);

`ifdef CAM_MASK_EN
    wr(2, 14'h00F0);
    idle(); match_en = 1'b1; key = 14'h00FF; key_mask = 14'h000F; tick(); idle(); tick();
    check("mask_hit", hit, 1); check("mask_addr", match_addr, 2);
    search(14'h00FF);
    check("mask0_hit", hit, 0);
`endif

    pool[0] = 14'h0001; pool[1] = 14'h0ABC; pool[2] = 14'h1111; pool[3] = 14'h3FFF;
    for (int n = 0; n < 600; n++) begin
      idle();
      rst      = ($urandom_range(0, 79) == 0);
      we       = ($urandom_range(0, 2) == 0);
      clr_en   = ($urandom_range(0, 5) == 0);
      rd_en    = $urandom_range(0, 1) != 0;
      match_en = $urandom_range(0, 1) != 0;
      addr     = ADDR_W'($urandom_range(0, DEPTH - 1));
      din      = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom) : pool[$urandom_range(0, 3)];
      key      = ($urandom_range(0, 5) == 0) ? DATA_W'($urandom) : pool[$urandom_range(0, 3)];
`ifdef CAM_MASK_EN
      key_mask = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom & $urandom) : '0;
`endif
      tick();
    end
    idle(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
